// File: rtl/stride_decoder_pkg.sv
// Shared definitions for the stride decoder and the pattern counter that
// produces the coordinates it observes.
//   step_mode_e : 2-bit step-mode encoding (00=0, 01=1, 10=4, 11=8)
//   step_delta  : coordinate delta associated with a step mode
//   state_e     : decoder FSM states
package stride_decoder_pkg;

    typedef enum logic [1:0] {
        MODE_0 = 2'b00,
        MODE_1 = 2'b01,
        MODE_4 = 2'b10,
        MODE_8 = 2'b11
    } step_mode_e;

    localparam int unsigned STEP_DELTA_0 = 0;
    localparam int unsigned STEP_DELTA_1 = 1;
    localparam int unsigned STEP_DELTA_4 = 4;
    localparam int unsigned STEP_DELTA_8 = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HAVE_PREV = 2'd1,
        ST_ACQUIRE   = 2'd2,
        ST_LOCKED    = 2'd3
    } state_e;

    function automatic int unsigned step_delta(input step_mode_e m);
        case (m)
            MODE_0:  step_delta = STEP_DELTA_0;
            MODE_1:  step_delta = STEP_DELTA_1;
            MODE_4:  step_delta = STEP_DELTA_4;
            default: step_delta = STEP_DELTA_8;
        endcase
    endfunction

endpackage

// File: rtl/delta_classify.sv
// Combinational classifier: maps a coordinate delta onto a step mode.
//   delta_i : coordinate delta, modulo 2^W
//   class_o : step mode whose delta equals delta_i (MODE_0 when illegal)
//   legal_o : delta_i is one of the step-mode deltas
module delta_classify
    import stride_decoder_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] delta_i,
    output step_mode_e   class_o,
    output logic         legal_o
);

    always_comb begin
        class_o = MODE_0;
        legal_o = 1'b1;
        if (delta_i == W'(step_delta(MODE_0)))
            class_o = MODE_0;
        else if (delta_i == W'(step_delta(MODE_1)))
            class_o = MODE_1;
        else if (delta_i == W'(step_delta(MODE_4)))
            class_o = MODE_4;
        else if (delta_i == W'(step_delta(MODE_8)))
            class_o = MODE_8;
        else
            legal_o = 1'b0;
    end

endmodule

// File: rtl/stride_decoder.sv
// Stride decoder: watches a coordinate stream and locks onto its step mode
// once LOCK_COUNT consecutive equal legal deltas have been seen.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over in_valid
//   in_valid   : in_coord carries a sample
//   in_coord   : observed coordinate
//   xmode      : last locked step mode (held after lock loss)
//   locked     : decoder locked to xmode
//   err        : one-cycle pulse on illegal delta or lock loss
//   match_cnt  : run length of equal legal deltas, saturating at 15
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | no history; next sample is only captured
// ST_HAVE_PREV | previous coordinate known, no candidate mode
// ST_ACQUIRE   | counting consecutive deltas equal to cand_q
// ST_LOCKED    | LOCK_COUNT matches reached, tracking xmode
module stride_decoder
    import stride_decoder_pkg::*;
#(
    parameter int W          = 12,
    parameter int LOCK_COUNT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_coord,
    output logic [1:0]   xmode,
    output logic         locked,
    output logic         err,
    output logic [3:0]   match_cnt
);

    state_e       state_q;
    step_mode_e   xmode_q;
    step_mode_e   cand_q;
    logic         locked_q;
    logic         err_q;
    logic [3:0]   match_cnt_q;
    logic [W-1:0] prev_q;

    logic [W-1:0] delta;
    step_mode_e   delta_class;
    logic         delta_legal;
    logic [3:0]   match_inc;

    // Unsigned subtraction wraps naturally, so 4095 -> 3 yields 4.
    assign delta     = in_coord - prev_q;
    assign match_inc = match_cnt_q + 4'd1;

    delta_classify #(.W(W)) u_classify (
        .delta_i (delta),
        .class_o (delta_class),
        .legal_o (delta_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            xmode_q     <= MODE_0;
            cand_q      <= MODE_0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            match_cnt_q <= 4'd0;
            prev_q      <= '0;
        end else if (clr) begin
            state_q     <= ST_IDLE;
            xmode_q     <= MODE_0;
            cand_q      <= MODE_0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            match_cnt_q <= 4'd0;
        end else begin
            err_q <= 1'b0;
            if (in_valid) begin
                prev_q <= in_coord;
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_HAVE_PREV;
                    end
                    ST_HAVE_PREV: begin
                        if (delta_legal) begin
                            cand_q      <= delta_class;
                            match_cnt_q <= 4'd1;
                            state_q     <= ST_ACQUIRE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!delta_legal) begin
                            err_q       <= 1'b1;
                            match_cnt_q <= 4'd0;
                            state_q     <= ST_HAVE_PREV;
                        end else if (delta_class == cand_q) begin
                            match_cnt_q <= match_inc;
                            if (match_inc == 4'(LOCK_COUNT)) begin
                                state_q  <= ST_LOCKED;
                                xmode_q  <= cand_q;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            cand_q      <= delta_class;
                            match_cnt_q <= 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!delta_legal) begin
                            err_q       <= 1'b1;
                            locked_q    <= 1'b0;
                            match_cnt_q <= 4'd0;
                            state_q     <= ST_HAVE_PREV;
                        end else if (delta_class == xmode_q) begin
                            if (match_cnt_q != 4'hF)
                                match_cnt_q <= match_inc;
                        end else begin
                            err_q       <= 1'b1;
                            locked_q    <= 1'b0;
                            cand_q      <= delta_class;
                            match_cnt_q <= 4'd1;
                            state_q     <= ST_ACQUIRE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign xmode     = xmode_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_stride_decoder.sv
module tb_stride_decoder;
    import stride_decoder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [11:0] in_coord;
    logic [1:0]  xmode;
    logic        locked;
    logic        err;
    logic [3:0]  match_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [11:0] coord;
        logic [1:0]  xm;
        logic        lk;
        logic        er;
        logic [3:0]  mc;
    } vec_t;

    typedef struct {
        logic [1:0] xm;
        logic       lk;
        logic       er;
        logic [3:0] mc;
        string      nm;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    stride_decoder #(.W(12), .LOCK_COUNT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_coord  (in_coord),
        .xmode     (xmode),
        .locked    (locked),
        .err       (err),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic v, input int co,
                                input int xm, input logic lk, input logic er, input int mc);
        vec_t r;
        r.clr = c; r.vld = v; r.coord = 12'(co);
        r.xm = 2'(xm); r.lk = lk; r.er = er; r.mc = 4'(mc);
        return r;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        @(negedge clk);
        clr      = v.clr;
        in_valid = v.vld;
        in_coord = v.coord;
        exp_q.push_back('{xm: v.xm, lk: v.lk, er: v.er, mc: v.mc, nm: nm});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.nm, ".xmode"},     int'(xmode),     int'(e.xm));
        chk({e.nm, ".locked"},    int'(locked),    int'(e.lk));
        chk({e.nm, ".err"},       int'(err),       int'(e.er));
        chk({e.nm, ".match_cnt"}, int'(match_cnt), int'(e.mc));
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_coord = '0;
        #2;
        chk("reset.xmode", int'(xmode), 0);
        chk("reset.locked", int'(locked), 0);
        chk("reset.err", int'(err), 0);
        chk("reset.match_cnt", int'(match_cnt), 0);
        #10 rst_n = 1'b1;

        // stride 1 lock, hold on idle, clr while locked
        tbl.push_back(mk(0,1, 100, 0,0,0,0));
        tbl.push_back(mk(0,1, 101, 0,0,0,1));
        tbl.push_back(mk(0,1, 102, 0,0,0,2));
        tbl.push_back(mk(0,1, 103, 0,0,0,3));
        tbl.push_back(mk(0,1, 104, 1,1,0,4));
        tbl.push_back(mk(0,0, 999, 1,1,0,4));
        tbl.push_back(mk(0,1, 105, 1,1,0,5));
        tbl.push_back(mk(1,1, 106, 0,0,0,0));
        tbl.push_back(mk(0,1, 500, 0,0,0,0));
        tbl.push_back(mk(0,1, 501, 0,0,0,1));
        // illegal deltas in HAVE_PREV and ACQUIRE, candidate switch
        tbl.push_back(mk(1,0,   0, 0,0,0,0));
        tbl.push_back(mk(0,1,4092, 0,0,0,0));
        tbl.push_back(mk(0,1,4094, 0,0,1,0));
        tbl.push_back(mk(0,1,4095, 0,0,0,1));
        tbl.push_back(mk(0,1,   0, 0,0,0,2));
        tbl.push_back(mk(0,1,   3, 0,0,1,0));
        tbl.push_back(mk(0,1,   4, 0,0,0,1));
        tbl.push_back(mk(0,1,   8, 0,0,0,1));
        tbl.push_back(mk(0,1,  12, 0,0,0,2));
        // stride 8 lock, crossing the wrap
        tbl.push_back(mk(1,0,   0, 0,0,0,0));
        tbl.push_back(mk(0,1,4056, 0,0,0,0));
        tbl.push_back(mk(0,1,4064, 0,0,0,1));
        tbl.push_back(mk(0,1,4072, 0,0,0,2));
        tbl.push_back(mk(0,1,4080, 0,0,0,3));
        tbl.push_back(mk(0,1,4088, 3,1,0,4));
        tbl.push_back(mk(0,1,   0, 3,1,0,5));
        tbl.push_back(mk(0,1,   8, 3,1,0,6));
        // stride 4 lock with wrap, lose to stride 1, relock, illegal in LOCKED
        tbl.push_back(mk(1,0,   0, 0,0,0,0));
        tbl.push_back(mk(0,1,4087, 0,0,0,0));
        tbl.push_back(mk(0,1,4091, 0,0,0,1));
        tbl.push_back(mk(0,1,4095, 0,0,0,2));
        tbl.push_back(mk(0,1,   3, 0,0,0,3));
        tbl.push_back(mk(0,1,   7, 2,1,0,4));
        tbl.push_back(mk(0,1,   8, 2,0,1,1));
        tbl.push_back(mk(0,1,   9, 2,0,0,2));
        tbl.push_back(mk(0,1,  10, 2,0,0,3));
        tbl.push_back(mk(0,1,  11, 1,1,0,4));
        tbl.push_back(mk(0,1,  13, 1,0,1,0));
        tbl.push_back(mk(0,1,  14, 1,0,0,1));
        tbl.push_back(mk(0,1,  15, 1,0,0,2));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset mid-ACQUIRE: outputs clear before the next edge
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.xmode", int'(xmode), 0);
        chk("async_rst.locked", int'(locked), 0);
        chk("async_rst.err", int'(err), 0);
        chk("async_rst.match_cnt", int'(match_cnt), 0);
        #1 rst_n = 1'b1;
        apply(mk(0,1, 300, 0,0,0,0), "post_rst_capture");
        apply(mk(0,1, 301, 0,0,0,1), "post_rst_d1");
        apply(mk(0,1, 302, 0,0,0,2), "post_rst_d2");
        apply(mk(0,1, 303, 0,0,0,3), "post_rst_d3");
        apply(mk(0,1, 304, 1,1,0,4), "post_rst_lock");

        // illegal delta leaves the FSM waiting in HAVE_PREV
        apply(mk(1,0,    0, 0,0,0,0), "hp_clr");
        apply(mk(0,1, 4092, 0,0,0,0), "hp_capture");
        apply(mk(0,1, 4094, 0,0,1,0), "hp_illegal");
        chk("hp_state", int'(dut.state_q), int'(ST_HAVE_PREV));
        apply(mk(0,0, 4094, 0,0,0,0), "hp_err_cleared");

        // stride 0 lock, match_cnt saturates at 15
        apply(mk(1,0, 0, 0,0,0,0), "sat_clr");
        apply(mk(0,1, 50, 0,0,0,0), "sat_capture");
        for (int k = 1; k <= 17; k++)
            apply(mk(0,1, 50, 0, (k >= 4), 0, (k > 15) ? 15 : k),
                  $sformatf("sat%0d", k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stride_decoder.md
STRIDE_DECODER -- requirements
Module: stride_decoder

Interface
REQ-001 SHALL have parameter W, default 12: coordinate width in bits.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: number of consecutive equal legal deltas needed to lock; legal range 2..15.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clr, input, 1: synchronous clear, active high.
REQ-006 SHALL have port in_valid, input, 1: in_coord carries a sample this cycle.
REQ-007 SHALL have port in_coord, input, W: observed coordinate from the pattern counter.
REQ-008 SHALL have port xmode, output, 2: decoded step mode (00=0, 01=1, 10=4, 11=8), registered.
REQ-009 SHALL have port locked, output, 1: decoder is locked to xmode, registered.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on an illegal delta or a loss of lock, registered.
REQ-011 SHALL have port match_cnt, output, 4: current run length of equal legal deltas, registered, saturating at 15.

Function
REQ-012 SHALL compute delta = (in_coord - prev) mod 2^W; prev is updated with in_coord on every in_valid cycle, except in IDLE where it is only captured.
REQ-013 SHALL classify delta 0/1/4/8 as class 00/01/10/11; any other value is illegal.
REQ-014 SHALL implement states IDLE, HAVE_PREV, ACQUIRE, LOCKED; in_valid=0 holds all state and outputs, with err=0.
REQ-015 IDLE: on in_valid, SHALL capture prev and go to HAVE_PREV; no err.
REQ-016 HAVE_PREV: on legal delta SHALL set cand=class, match_cnt=1 and go to ACQUIRE; on illegal delta SHALL pulse err and stay.
REQ-017 ACQUIRE: on delta equal to cand SHALL increment match_cnt; when the new count equals LOCK_COUNT SHALL go to LOCKED, with xmode=cand and locked=1 in the same update.
REQ-018 ACQUIRE: on a legal delta different from cand SHALL set cand=class and match_cnt=1, with no err; on an illegal delta SHALL pulse err, set match_cnt=0 and go to HAVE_PREV.
REQ-019 LOCKED: on delta equal to xmode SHALL hold state and increment match_cnt, saturating at 15.
REQ-020 LOCKED: on a mismatching legal delta SHALL pulse err, clear locked, set cand=class and match_cnt=1, and go to ACQUIRE.
REQ-021 LOCKED: on an illegal delta SHALL pulse err, clear locked, set match_cnt=0 and go to HAVE_PREV.
REQ-022 xmode SHALL hold its last locked value after lock loss, until the next lock or a clear.
REQ-023 Wrap-around SHALL be legal: prev=4095 and in_coord=3 gives delta 4 (class 10).
REQ-024 clr SHALL have priority over in_valid: next state IDLE, locked=0, err=0, match_cnt=0, xmode=00, and the sample in that cycle is discarded.
REQ-025 Latency SHALL be one cycle from the sampled input to every output.

Reset
REQ-026 While rst_n=0, SHALL immediately force state=IDLE, xmode=00, locked=0, err=0, match_cnt=0, prev=0 and cand=00.
REQ-027 Reset asserted mid-acquire or while locked SHALL discard all history; the first sample after release is treated as an IDLE capture.

Structure
REQ-028 Step-mode encodings (00..11) and their delta values (0,1,4,8) SHALL live in a shared package, also used by the pattern counter.
REQ-029 The FSM state enum SHALL be defined in that shared package.
REQ-030 The delta classifier SHALL be a separate combinational sub-module, delta_classify (inputs delta; outputs class, legal).

Verification
REQ-031 Bench SHALL drive 100,101,102,103,104 on consecutive cycles -> locked=1 and xmode=01 the cycle after 104; err never asserted.
REQ-032 Bench SHALL drive 4092,4094(illegal delta 2),4095... -> err pulse for exactly one cycle, state HAVE_PREV, match_cnt=0.
REQ-033 Bench SHALL lock on stride 8 from 4072, crossing 4088,0,8 -> stays locked, xmode=11, no err at the wrap.
REQ-034 Bench SHALL lock on stride 4, then drive a delta of 1 -> err pulse, locked=0, match_cnt=1, xmode stays 10; three more deltas of 1 -> relock with xmode=01.
REQ-035 Bench SHALL assert clr in the same cycle as in_valid while locked -> IDLE with all outputs zero; the next sample is only captured and raises no err.
REQ-036 Bench SHALL pulse rst_n low asynchronously mid-ACQUIRE (match_cnt=2) -> outputs zero before the next clock edge; after release, a new lock needs the full LOCK_COUNT deltas.
